// File: rtl/key_switch_debouncer.sv
// Conditions raw pushbuttons and slide switches for the memory-mapped I/O block.
// Each input is synchronised and then bounce-filtered. Keys are active-low on the pins and
// active-high on the outputs. Each key also produces a one-cycle press pulse and sets a sticky
// latch, which software clears by mask.
module key_switch_debouncer #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned NUM_SWITCHES    = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic [NUM_KEYS-1:0]     keysRaw,
    input  logic [NUM_SWITCHES-1:0] switchesRaw,
    input  logic [NUM_KEYS-1:0]     clearKeys,
    output logic [NUM_KEYS-1:0]     keys,
    output logic [NUM_SWITCHES-1:0] switches,
    output logic [NUM_KEYS-1:0]     keyPress,
    output logic [NUM_KEYS-1:0]     keyLatch
);

    // Keys occupy the low bits and switches the high bits of one shared filter vector.
    localparam int unsigned NumBits = NUM_KEYS + NUM_SWITCHES;
    localparam int unsigned CntW    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] TermCnt = CntW'(DEBOUNCE_CYCLES - 1);
    // Idle pin levels: keys released (1), switches low (0).
    localparam logic [NumBits-1:0] SyncIdle = {{NUM_SWITCHES{1'b0}}, {NUM_KEYS{1'b1}}};

    logic [NumBits-1:0]  rawAll;
    logic [NumBits-1:0]  syncMetaQ;
    logic [NumBits-1:0]  syncQ;
    logic [NumBits-1:0]  syncLevel;
    logic [NumBits-1:0]  debQ;
    logic [NumBits-1:0]  debD;
    logic [CntW-1:0]     cntQ [NumBits];
    logic [CntW-1:0]     cntD [NumBits];
    logic [NUM_KEYS-1:0] keysPrevQ;
    logic [NUM_KEYS-1:0] pressQ;
    logic [NUM_KEYS-1:0] pressD;
    logic [NUM_KEYS-1:0] latchQ;
    logic [NUM_KEYS-1:0] latchD;

    assign rawAll = {switchesRaw, keysRaw};

    // Key levels are inverted after the synchroniser so that 1 means pressed from here on.
    assign syncLevel = {syncQ[NumBits-1:NUM_KEYS], ~syncQ[NUM_KEYS-1:0]};

    // Two-flop synchroniser. On reset it loads the idle pin levels, not zero.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            syncMetaQ <= SyncIdle;
            syncQ     <= SyncIdle;
        end else begin
            syncMetaQ <= rawAll;
            syncQ     <= syncMetaQ;
        end
    end

    // Per-bit stability counter. It accepts a change only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples. Any agreeing sample restarts the count.
    always_comb begin
        debD = debQ;
        for (int i = 0; i < NumBits; i++) begin
            cntD[i] = '0;
            if (syncLevel[i] != debQ[i]) begin
                if (cntQ[i] == TermCnt) begin
                    debD[i] = syncLevel[i];
                end else begin
                    cntD[i] = cntQ[i] + 1'b1;
                end
            end
        end
    end

    // Filter state. Reset discards any pending change.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            debQ <= '0;
            for (int i = 0; i < NumBits; i++) begin
                cntQ[i] <= '0;
            end
        end else begin
            debQ <= debD;
            for (int i = 0; i < NumBits; i++) begin
                cntQ[i] <= cntD[i];
            end
        end
    end

    // Detect rising edges on the debounced keys. A set of the latch beats a clear in the
    // same cycle, so a press is never lost to a racing software clear.
    always_comb begin
        pressD = debQ[NUM_KEYS-1:0] & ~keysPrevQ;
        latchD = (latchQ & ~clearKeys) | pressQ;
    end

    // Press pulse and sticky latch registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            keysPrevQ <= '0;
            pressQ    <= '0;
            latchQ    <= '0;
        end else begin
            keysPrevQ <= debQ[NUM_KEYS-1:0];
            pressQ    <= pressD;
            latchQ    <= latchD;
        end
    end

    assign keys     = debQ[NUM_KEYS-1:0];
    assign switches = debQ[NumBits-1:NUM_KEYS];
    assign keyPress = pressQ;
    assign keyLatch = latchQ;

endmodule

// File: tb/tb_key_switch_debouncer.sv
// Bench for key_switch_debouncer with DEBOUNCE_CYCLES=4.
// A sliding-window reference model pushes the expected outputs for each clock edge. The bench
// pops them and compares after that edge. Directed checks cover the cycle-exact points.
module tb_key_switch_debouncer;

    localparam int DB = 4;
    localparam int NB = 14;

    typedef struct packed {
        logic [3:0] keys;
        logic [9:0] sw;
        logic [3:0] press;
        logic [3:0] latch;
    } outs_t;

    logic       clk;
    logic       resetN;
    logic [3:0] keysRaw;
    logic [9:0] switchesRaw;
    logic [3:0] clearKeys;
    logic [3:0] keys;
    logic [9:0] switches;
    logic [3:0] keyPress;
    logic [3:0] keyLatch;

    int total = 0;
    int bad   = 0;

    outs_t sb[$];

    // Reference model state.
    logic [NB-1:0] mS1, mS2, mDeb;
    logic [NB-1:0] mHist [DB];
    logic [3:0]    mKeysPrev, mPress, mLatch;

    key_switch_debouncer #(
        .NUM_KEYS        (4),
        .NUM_SWITCHES    (10),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .keysRaw     (keysRaw),
        .switchesRaw (switchesRaw),
        .clearKeys   (clearKeys),
        .keys        (keys),
        .switches    (switches),
        .keyPress    (keyPress),
        .keyLatch    (keyLatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mS1       = {10'h000, 4'hF};
        mS2       = {10'h000, 4'hF};
        for (int j = 0; j < DB; j++) mHist[j] = '0;
        mDeb      = '0;
        mKeysPrev = '0;
        mPress    = '0;
        mLatch    = '0;
    endtask

    // A bit flips once the last DB synchronised samples all disagree with its current level.
    task automatic modelStep();
        logic [NB-1:0] cur;
        logic [NB-1:0] newDeb;
        logic [3:0]    newPress;
        logic [3:0]    newLatch;
        bit            allDiff;
        cur = {mS2[13:4], ~mS2[3:0]};
        for (int j = DB - 1; j > 0; j--) mHist[j] = mHist[j-1];
        mHist[0] = cur;
        newDeb = mDeb;
        for (int i = 0; i < NB; i++) begin
            allDiff = 1'b1;
            for (int j = 0; j < DB; j++) if (mHist[j][i] == mDeb[i]) allDiff = 1'b0;
            if (allDiff) newDeb[i] = ~mDeb[i];
        end
        newPress = mDeb[3:0] & ~mKeysPrev;
        for (int i = 0; i < 4; i++)
            newLatch[i] = mPress[i] ? 1'b1 : (clearKeys[i] ? 1'b0 : mLatch[i]);
        mLatch    = newLatch;
        mPress    = newPress;
        mKeysPrev = mDeb[3:0];
        mDeb      = newDeb;
        mS2       = mS1;
        mS1       = {switchesRaw, keysRaw};
    endtask

    // One rising edge. The model sees the inputs present before the edge, and the DUT is
    // sampled 1 time unit after it.
    task automatic tick();
        outs_t e;
        modelStep();
        e.keys  = mDeb[3:0];
        e.sw    = mDeb[13:4];
        e.press = mPress;
        e.latch = mLatch;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkEq("sb.keys",     32'(keys),     32'(e.keys));
        checkEq("sb.switches", 32'(switches), 32'(e.sw));
        checkEq("sb.keyPress", 32'(keyPress), 32'(e.press));
        checkEq("sb.keyLatch", 32'(keyLatch), 32'(e.latch));
    endtask

    task automatic checkAllZero(input string tag);
        checkEq({tag, ".keys"},     32'(keys),     32'h0);
        checkEq({tag, ".switches"}, 32'(switches), 32'h0);
        checkEq({tag, ".keyPress"}, 32'(keyPress), 32'h0);
        checkEq({tag, ".keyLatch"}, 32'(keyLatch), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        int         pulses;
        logic [9:0] seen;

        keysRaw     = 4'hF;
        switchesRaw = 10'h000;
        clearKeys   = 4'h0;
        resetN      = 1'b1;

        // 1. Reset with all keys held, so the outputs clear without a clock edge.
        #1;
        keysRaw = 4'h0;
        resetN  = 1'b0;
        modelReset();
        #1;
        checkAllZero("rst.async");
        #1;
        resetN = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 5) checkEq("rst.keys@5", 32'(keys), 32'h0);
            if (c == 6) checkEq("rst.keys@6", 32'(keys), 32'hF);
            if (c == 7) checkEq("rst.press@7", 32'(keyPress), 32'hF);
            if (c == 8) begin
                checkEq("rst.press@8", 32'(keyPress), 32'h0);
                checkEq("rst.latch@8", 32'(keyLatch), 32'hF);
            end
        end
        // Release all keys, which must produce no pulse, then clear the latches.
        keysRaw = 4'hF;
        repeat (8) tick();
        checkEq("release.keys", 32'(keys), 32'h0);
        clearKeys = 4'hF;
        tick();
        clearKeys = 4'h0;
        tick();
        checkEq("clear.latch", 32'(keyLatch), 32'h0);

        // 2. Clean press on key 0.
        keysRaw[0] = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 5) checkEq("press.keys@5", 32'(keys), 32'h0);
            if (c == 6) checkEq("press.keys@6", 32'(keys), 32'h1);
            if (c == 7) checkEq("press.pulse@7", 32'(keyPress), 32'h1);
            if (c == 8) begin
                checkEq("press.pulse@8", 32'(keyPress), 32'h0);
                checkEq("press.latch@8", 32'(keyLatch), 32'h1);
            end
        end

        // 3. Bounce on key 1: 0,1,0,1 then hold 0.
        pat    = 4'b0101;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            keysRaw[1] = pat[3-k];
            tick();
            pulses += int'(keyPress[1]);
        end
        keysRaw[1] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            pulses += int'(keyPress[1]);
            if (c == 5) checkEq("bounce.keys1@5", 32'(keys[1]), 32'h0);
            if (c == 6) checkEq("bounce.keys1@6", 32'(keys[1]), 32'h1);
        end
        checkEq("bounce.pulses", 32'(pulses), 32'd1);

        // 4. A 3-cycle glitch on switch 9 is rejected and a 4-cycle pulse is accepted.
        seen = 10'h000;
        switchesRaw[9] = 1'b1;
        repeat (3) begin
            tick();
            seen |= switches;
        end
        switchesRaw[9] = 1'b0;
        repeat (8) begin
            tick();
            seen |= switches;
        end
        checkEq("glitch.seen", 32'(seen), 32'h0);
        for (int c = 1; c <= 12; c++) begin
            switchesRaw[9] = (c <= 4);
            tick();
            if (c == 5) checkEq("pulse4.sw@5", 32'(switches), 32'h000);
            if (c == 6) checkEq("pulse4.sw@6", 32'(switches), 32'h200);
        end

        // 5. A clear of key 2 that collides with its press pulse loses to the set.
        keysRaw[2] = 1'b0;
        repeat (7) tick();
        checkEq("coll.press", 32'(keyPress), 32'h4);
        clearKeys = 4'b0100;
        tick();
        checkEq("coll.latchSet", 32'(keyLatch[2]), 32'h1);
        tick();
        checkEq("coll.latchClr", 32'(keyLatch[2]), 32'h0);
        clearKeys = 4'h0;
        tick();

        // 6. Reset in the middle of a switch count restarts the full latency.
        switchesRaw[0] = 1'b1;
        repeat (4) tick();
        checkEq("midrst.pre", 32'(switches), 32'h0);
        resetN = 1'b0;
        modelReset();
        #1;
        checkAllZero("midrst.async");
        #1;
        resetN = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 5) checkEq("midrst.sw0@5", 32'(switches[0]), 32'h0);
            if (c == 6) checkEq("midrst.sw0@6", 32'(switches[0]), 32'h1);
        end

        // 7. Random slow toggling and clears, checked only against the model.
        repeat (400) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) keysRaw[b] = ~keysRaw[b];
            for (int b = 0; b < 10; b++)
                if ($urandom_range(7) == 0) switchesRaw[b] = ~switchesRaw[b];
            clearKeys = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'h0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
